// File: rtl/vga_timing_ctrl_if.sv
// rtl/vga_timing_ctrl_if.sv - run enable plus scan coordinates, syncs and strobes of the VGA timing controller
interface vga_timing_ctrl_if;
  logic       en;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       pix_tick;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       trig_v;
  logic       frame_start;

  modport master (
    input  en,
    output h_count, v_count, pix_tick, hsync, vsync, video_on, trig_v, frame_start
  );

  modport slave (
    output en,
    input  h_count, v_count, pix_tick, hsync, vsync, video_on, trig_v, frame_start
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA scan counters with per-axis ACTIVE/FRONT/SYNC/BACK phase machines
// Reset parks on the last blanking pixel so the first pixel tick after release lands on (0,0).
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_DIV  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vga_timing_ctrl_if.master      vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FRONT_AT = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_AT  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BACK_AT  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FRONT_AT = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_AT  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BACK_AT  = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  phase_t           r_h_ph;
  phase_t           r_v_ph;
  phase_t           w_h_ph_nxt;
  phase_t           w_v_ph_nxt;
  logic             w_tick;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [9:0]       w_h_nxt;
  logic [9:0]       w_v_nxt;
  logic             w_hsync_nxt;
  logic             w_vsync_nxt;
  logic             w_video_nxt;
  logic             r_pix_tick;
  logic             r_trig_v;
  logic             r_frame_start;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;

  assign w_tick   = vif.en && (r_div == DIV_LAST);
  assign w_h_wrap = w_tick && (r_h == H_LAST);
  assign w_v_wrap = w_h_wrap && (r_v == V_LAST);
  assign w_h_nxt  = !w_tick   ? r_h : ((r_h == H_LAST) ? 10'd0 : r_h + 10'd1);
  assign w_v_nxt  = !w_h_wrap ? r_v : ((r_v == V_LAST) ? 10'd0 : r_v + 10'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
      r_h   <= H_LAST;
      r_v   <= V_LAST;
    end else begin
      if (vif.en) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      end
      r_h <= w_h_nxt;
      r_v <= w_v_nxt;
    end
  end

  // A phase advances on the tick whose next counter value is the first of the following region.
  function automatic phase_t next_phase(input phase_t cur, input logic adv, input logic [9:0] nxt,
                                        input logic [9:0] front_at, input logic [9:0] sync_at,
                                        input logic [9:0] back_at);
    phase_t n;
    n = cur;
    if (adv) begin
      case (cur)
        PH_ACTIVE: if (nxt == front_at) n = PH_FRONT;
        PH_FRONT:  if (nxt == sync_at)  n = PH_SYNC;
        PH_SYNC:   if (nxt == back_at)  n = PH_BACK;
        PH_BACK:   if (nxt == 10'd0)    n = PH_ACTIVE;
        default:   n = PH_BACK;
      endcase
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_ph <= PH_BACK;
      r_v_ph <= PH_BACK;
    end else begin
      r_h_ph <= w_h_ph_nxt;
      r_v_ph <= w_v_ph_nxt;
    end
  end

  always_comb begin
    w_h_ph_nxt = next_phase(r_h_ph, w_tick,   w_h_nxt, H_FRONT_AT, H_SYNC_AT, H_BACK_AT);
    w_v_ph_nxt = next_phase(r_v_ph, w_h_wrap, w_v_nxt, V_FRONT_AT, V_SYNC_AT, V_BACK_AT);
  end

  // Levels decode the next phase so they land on the same edge as the coordinates.
  always_comb begin
    w_hsync_nxt = 1'b1;
    w_vsync_nxt = 1'b1;
    w_video_nxt = 1'b0;
    if (w_h_ph_nxt == PH_SYNC) w_hsync_nxt = 1'b0;
    if (w_v_ph_nxt == PH_SYNC) w_vsync_nxt = 1'b0;
    if ((w_h_ph_nxt == PH_ACTIVE) && (w_v_ph_nxt == PH_ACTIVE)) w_video_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b0;
      r_pix_tick    <= 1'b0;
      r_trig_v      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_video_on    <= w_video_nxt;
      r_pix_tick    <= w_tick;
      r_trig_v      <= w_h_wrap;
      r_frame_start <= w_v_wrap;
    end
  end

  assign vif.h_count     = r_h;
  assign vif.v_count     = r_v;
  assign vif.pix_tick    = r_pix_tick;
  assign vif.hsync       = r_hsync;
  assign vif.vsync       = r_vsync;
  assign vif.video_on    = r_video_on;
  assign vif.trig_v      = r_trig_v;
  assign vif.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - scoreboard bench for vga_timing_ctrl on a shrunken raster
module tb_vga_timing_ctrl;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * PD;

  typedef struct {
    int h, v, tick, hs, vs, vo, tr, fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vga_timing_ctrl_if vif ();

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_DIV(PD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vif  (vif)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int n_chk = 0, n_err = 0;
  int m_h, m_v, m_div;
  int cyc = 0, n_fs = 0, n_tr = 0, n_tick = 0, n_hs_low = 0, n_vs_low = 0;
  int last_fs = -1, fs_gap = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic clear_stats();
    n_fs = 0; n_tr = 0; n_tick = 0; n_hs_low = 0; n_vs_low = 0; last_fs = -1; fs_gap = 0;
  endtask

  task automatic step(input logic r, input logic e);
    exp_t x;
    rst_n  = r;
    vif.en = e;
    x.tick = 0; x.tr = 0; x.fs = 0;
    if (!r) begin
      m_h = HT - 1; m_v = VT - 1; m_div = 0;
    end else if (e) begin
      if (m_div == PD - 1) begin
        m_div  = 0;
        x.tick = 1;
        if (m_h == HT - 1) begin
          m_h  = 0;
          x.tr = 1;
          if (m_v == VT - 1) begin
            m_v  = 0;
            x.fs = 1;
          end else m_v++;
        end else m_h++;
      end else m_div++;
    end
    x.h  = m_h;
    x.v  = m_v;
    x.hs = (m_h >= HA + HF && m_h < HA + HF + HS) ? 0 : 1;
    x.vs = (m_v >= VA + VF && m_v < VA + VF + VS) ? 0 : 1;
    x.vo = (m_h < HA && m_v < VA) ? 1 : 0;
    q.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
    x = q.pop_front();
    check("h_count",     vif.h_count,     x.h);
    check("v_count",     vif.v_count,     x.v);
    check("pix_tick",    vif.pix_tick,    x.tick);
    check("hsync",       vif.hsync,       x.hs);
    check("vsync",       vif.vsync,       x.vs);
    check("video_on",    vif.video_on,    x.vo);
    check("trig_v",      vif.trig_v,      x.tr);
    check("frame_start", vif.frame_start, x.fs);
    if (vif.pix_tick) n_tick++;
    if (vif.trig_v) n_tr++;
    if (!vif.hsync) n_hs_low++;
    if (!vif.vsync) n_vs_low++;
    if (vif.frame_start) begin
      n_fs++;
      if (last_fs >= 0) fs_gap = cyc - last_fs;
      last_fs = cyc;
    end
  endtask

  initial begin
    int k;
    vif.en = 1'b1;
    m_h = HT - 1; m_v = VT - 1; m_div = 0;

    repeat (3) step(1'b0, 1'b1);

    clear_stats();
    repeat (2 * FRAME_CLK) step(1'b1, 1'b1);
    check("frames_seen",   n_fs,     2);
    check("frame_gap_clk", fs_gap,   FRAME_CLK);
    check("lines_seen",    n_tr,     2 * VT);
    check("hsync_low_clk", n_hs_low, 2 * VT * HS * PD);
    check("vsync_low_clk", n_vs_low, 2 * VS * HT * PD);
    check("ticks_seen",    n_tick,   2 * HT * VT);

    for (int i = 0; i < 1000 && m_h != HA + HF; i++) step(1'b1, 1'b1);
    check("reach_freeze_h", vif.h_count, HA + HF);
    clear_stats();
    repeat (50) step(1'b1, 1'b0);
    check("freeze_ticks",  n_tick, 0);
    check("freeze_trig",   n_tr,   0);
    check("freeze_h_hold", vif.h_count, HA + HF);
    repeat (PD) step(1'b1, 1'b1);
    check("resume_h", vif.h_count, HA + HF + 1);

    for (int i = 0; i < 1000 && !(m_v == 2 && m_h == 5); i++) step(1'b1, 1'b1);
    check("reach_mid_v", vif.v_count, 2);
    step(1'b0, 1'b1);
    k = 0;
    clear_stats();
    for (int i = 0; i < 10 && n_fs == 0; i++) begin
      step(1'b1, 1'b1);
      k++;
    end
    check("fs_after_rst_clk", k, PD);
    check("fs_after_rst_seen", n_fs, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequences the VGA horizontal and vertical scan counters from the system clock and produces pixel tick, sync, blanking and line/frame strobes. It sits between the board clock and the pixel/colour generator, and replaces the free-running horizontal counter with a parameterised controller. Each axis runs an explicit ACTIVE/FRONT/SYNC/BACK phase machine. All outputs are registered and glitch-free.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 2, clk cycles per pixel (≥1)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  run enable; low freezes all state
- h_count  out  10  pixel index within line, 0..H_TOTAL-1
- v_count  out  10  line index within frame, 0..V_TOTAL-1
- pix_tick  out  1  one-clk strobe, one per pixel period
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high when h_count<H_ACTIVE and v_count<V_ACTIVE
- trig_v  out  1  one-clk strobe at start of each line
- frame_start  out  1  one-clk strobe at start of each frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525). Both must be ≤1024 (10-bit counters).
- Divider: counts 0..PIX_DIV-1 while en=1. pix_tick=1 when divider = PIX_DIV-1. PIX_DIV=1 gives pix_tick=en.
- h_count: advances by 1 on each pix_tick; wraps from H_TOTAL-1 to 0.
- v_count: advances only when h_count wraps; wraps from V_TOTAL-1 to 0.
- Per-axis phase FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE. Each transition occurs on the tick at which the counter enters the next region. For H: FRONT at 640, SYNC at 656, BACK at 752, ACTIVE at 0.
- hsync=0 only in H SYNC (h 656..751). vsync=0 only in V SYNC (v 490..491).
- video_on=1 only when both phase FSMs are in ACTIVE.
- trig_v=1 for the clk cycle following the edge at which h_count becomes 0.
- frame_start=1 for the clk cycle following the edge at which h_count and v_count both become 0. trig_v is also high in that cycle.
- en=0: divider, counters, FSMs and level outputs hold their values. pix_tick, trig_v and frame_start are 0.

## Timing
- Reset (rst_n=0 at a clk edge) loads these values, overriding en:
  - h_count=H_TOTAL-1, v_count=V_TOTAL-1, both FSMs=BACK, divider=0
  - hsync=1, vsync=1, video_on=0, pix_tick=0, trig_v=0, frame_start=0
- Reset state is therefore the last blanking pixel, so the first pix_tick after release starts frame 0 at (0,0).
- Reset asserted mid-frame aborts the frame on that edge. No partial sync pulse is extended.
- First pix_tick occurs PIX_DIV clk cycles after the first enabled edge.
- Counters, FSMs, hsync, vsync and video_on all update on the same edge. Zero skew between coordinates and decoded levels.
- Strobes are registered: high exactly one clk cycle, never two consecutive cycles when PIX_DIV≥2.
- Period checks (defaults, PIX_DIV=2):
  - line = 1600 clk; hsync low for 192 clk
  - frame = 840000 clk; vsync low for 3200 clk
- Simultaneous h and v wrap: trig_v and frame_start are asserted in the same cycle.

## Test plan
- Reset: hold rst_n=0 for 3 clk with en=1 → h_count=799, v_count=524, hsync=1, vsync=1, video_on=0, all strobes 0.
- Tick spacing: release reset, en=1, PIX_DIV=2 → pix_tick every 2nd clk; first tick gives h=0, v=0, frame_start=1, trig_v=1, video_on=1.
- Horizontal timing: run one line → video_on falls at h=640, hsync low h=656..751, trig_v pulses every 1600 clk.
- Frame timing: run 2 frames → vsync low v=490..491 (3200 clk), frame_start spaced 840000 clk, v wraps 524→0.
- Enable freeze: drop en at h=700 for 50 clk → all counters and levels hold, no strobes; resumes at h=700.
- Reset mid-frame: assert rst_n=0 at v=200, h=300 → next edge shows reset values; after release, next frame_start occurs PIX_DIV clk later.
